axil_selftest_master: RTL

- AXI4-Lite master that exercises the axi_reg slave register file in hardware.
- Writes an incrementing pattern to NUM_REGS consecutive 32-bit registers, then reads each one back and compares it.
- Reports pass/fail and an error count.
- Sits directly upstream of the register slave and replaces the simulation master for on-board bring-up; its M_AXI port connects straight to the slave's S_AXI port.

---
 rtl/axil_selftest_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axil_selftest_master.sv
// axil_selftest_master: AXI4-Lite write/readback self-test master; define AXIL_SELFTEST_TIMEOUT_EN for per-handshake timeouts
module axil_selftest_master #(
    parameter int          C_M_AXI_ADDR_WIDTH = 4,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          NUM_REGS           = 4,
    parameter int          BASE_ADDR          = 0,
    parameter logic [31:0] SEED               = 32'h00000001,
    parameter int          TIMEOUT_CYCLES     = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [7:0]                      err_count,
`ifdef AXIL_SELFTEST_TIMEOUT_EN
    output logic                            timeout,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_t;

    localparam logic [3:0] LAST = 4'(NUM_REGS - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE = C_M_AXI_ADDR_WIDTH'(BASE_ADDR);

    if (NUM_REGS < 1 || NUM_REGS > 16 || C_M_AXI_DATA_WIDTH != 32 || BASE_ADDR % 4 != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axil_selftest_master: unsupported parameter combination");
    end

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [31:0] exp_data;
    logic        last, aw_ok, w_ok, err_inc, tmo, tmo_hit;

    assign last         = idx == LAST;
    assign exp_data     = SEED + 32'(idx);
    assign aw_ok        = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_ok         = !M_AXI_WVALID || M_AXI_WREADY;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_BREADY = state == WR_RESP;
    assign M_AXI_RREADY = state == RD_RESP;
    assign busy         = state != IDLE && state != FINISH;

`ifdef AXIL_SELFTEST_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        stalled;
    assign stalled = (state == WR_REQ  && !(aw_ok && w_ok)) ||
                     (state == WR_RESP && !M_AXI_BVALID)   ||
                     (state == RD_REQ  && !M_AXI_ARREADY)  ||
                     (state == RD_RESP && !M_AXI_RVALID);
    assign tmo_hit = stalled && !timeout && wait_cnt == 32'(TIMEOUT_CYCLES - 1);
    assign tmo     = timeout;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= state_nxt != state ? 32'd0 : wait_cnt + 32'd1;
            if (state == IDLE && start)
                timeout <= 1'b0;
            else if (tmo_hit)
                timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo     = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_inc   = 1'b0;
        case (state)
            IDLE:    if (start) begin
                state_nxt = WR_REQ;
                idx_nxt   = '0;
            end
            WR_REQ:  if (aw_ok && w_ok) state_nxt = tmo ? FINISH : WR_RESP;
            WR_RESP: if (M_AXI_BVALID) begin
                err_inc   = M_AXI_BRESP != 2'b00;
                state_nxt = last ? RD_REQ : WR_REQ;
                idx_nxt   = last ? 4'd0 : idx + 4'd1;
            end
            RD_REQ:  if (M_AXI_ARREADY) state_nxt = tmo ? FINISH : RD_RESP;
            RD_RESP: if (M_AXI_RVALID) begin
                err_inc   = M_AXI_RDATA != exp_data || M_AXI_RRESP != 2'b00;
                state_nxt = last ? FINISH : RD_REQ;
                idx_nxt   = last ? idx : idx + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
        // Response states have no VALID of ours to hold, so a timeout there ends the run at once
        if (tmo_hit) begin
            err_inc = 1'b1;
            if (state == WR_RESP || state == RD_RESP) state_nxt = FINISH;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idx           <= '0;
            err_count     <= '0;
            pass          <= 1'b0;
            done          <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_ARADDR  <= '0;
        end else begin
            idx  <= idx_nxt;
            done <= state == FINISH;
            if (state == IDLE && start) begin
                err_count <= '0;
                pass      <= 1'b0;
            end else if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (state == FINISH) pass <= err_count == 8'd0;
            if (state != WR_REQ && state_nxt == WR_REQ) begin
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                M_AXI_AWADDR  <= BASE + C_M_AXI_ADDR_WIDTH'({idx_nxt, 2'b00});
                M_AXI_WDATA   <= SEED + 32'(idx_nxt);
            end else begin
                if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
            end
            if (state != RD_REQ && state_nxt == RD_REQ) begin
                M_AXI_ARVALID <= 1'b1;
                M_AXI_ARADDR  <= BASE + C_M_AXI_ADDR_WIDTH'({idx_nxt, 2'b00});
            end else if (M_AXI_ARREADY)
                M_AXI_ARVALID <= 1'b0;
        end
    end
endmodule
